// File: rtl/fp_norm_round.sv
// rtl/fp_norm_round.sv - FP32 add/sub back end: normalise, round and pack with fflags
// One operation in flight; left normalisation walks SHIFT_STEP or 1 bit per cycle.
module fp_norm_round #(
    parameter int EXP_W      = 8,
    parameter int FRAC_W     = 23,
    parameter int SHIFT_STEP = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sign_in,
    input  logic                    eff_sub_in,
    input  logic [EXP_W-1:0]        exp_in,
    input  logic [2*FRAC_W+1:0]     mantissa_in,
    input  logic                    carry_in,
    input  logic [2:0]              grs_in,
    input  logic [2:0]              rm_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic [4:0]              fflags
);

    localparam int MW  = 2*FRAC_W + 2;
    localparam int TOP = MW - 1;
    localparam int EW  = EXP_W + 2;
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EONE = EW'(1);
    localparam logic signed [EW-1:0] ESTEP = EW'(SHIFT_STEP);

    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [MW:0]             w_q, w_d;
    logic signed [EW-1:0]    e_q, e_d;
    logic                    stk_q, stk_d;
    logic                    sign_q, sign_d;
    logic [2:0]              rm_q, rm_d;
    logic [EXP_W+FRAC_W:0]   result_q, result_d;
    logic [4:0]              fflags_q, fflags_d;

    logic                    grs_unused;
    logic [EXP_W-1:0]        exp_clamp;

    logic [FRAC_W-1:0]       frac, frac_fin;
    logic                    g, r, s, nx, inc, norm, ovf, ovf_max, uf;
    logic [FRAC_W+1:0]       msum;
    logic signed [EW-1:0]    e_fin;
    logic [EXP_W-1:0]        exp_field;
    logic [EXP_W+FRAC_W:0]   rnd_res;

    assign grs_unused = ^grs_in[2:1];
    assign exp_clamp  = (exp_in == '0) ? EXP_W'(1) : exp_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            w_q      <= '0;
            e_q      <= '0;
            stk_q    <= 1'b0;
            sign_q   <= 1'b0;
            rm_q     <= '0;
            result_q <= '0;
            fflags_q <= '0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            e_q      <= e_d;
            stk_q    <= stk_d;
            sign_q   <= sign_d;
            rm_q     <= rm_d;
            result_q <= result_d;
            fflags_q <= fflags_d;
        end
    end

    // Rounding datapath; only consumed in ROUND.
    always_comb begin
        frac = w_q[TOP-1 -: FRAC_W];
        g    = w_q[TOP-FRAC_W-1];
        r    = w_q[TOP-FRAC_W-2];
        s    = (|w_q[TOP-FRAC_W-3:0]) | stk_q;
        nx   = g | r | s;
        case (rm_q)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign_q & nx;
            RM_RUP:  inc = ~sign_q & nx;
            RM_RMM:  inc = g;
            default: inc = g & (r | s | frac[0]);
        endcase
        msum = {1'b0, w_q[TOP], frac} + (FRAC_W+2)'(inc);
        if (msum[FRAC_W+1]) begin
            e_fin    = e_q + EONE;
            frac_fin = '0;
            norm     = 1'b1;
        end else begin
            // a denormal carrying into the hidden bit lands on exponent 1 here
            e_fin    = e_q;
            frac_fin = msum[FRAC_W-1:0];
            norm     = msum[FRAC_W];
        end
        ovf       = norm && (e_fin >= EMAX);
        exp_field = norm ? e_fin[EXP_W-1:0] : '0;
        case (rm_q)
            RM_RTZ:  ovf_max = 1'b1;
            RM_RDN:  ovf_max = ~sign_q;
            RM_RUP:  ovf_max = sign_q;
            default: ovf_max = 1'b0;
        endcase
        if (ovf && ovf_max)
            rnd_res = {sign_q, {{(EXP_W-1){1'b1}}, 1'b0}, {FRAC_W{1'b1}}};
        else if (ovf)
            rnd_res = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        else
            rnd_res = {sign_q, exp_field, frac_fin};
        uf = ~ovf && (exp_field == '0) && nx;
    end

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        e_d      = e_q;
        stk_d    = stk_q;
        sign_d   = sign_q;
        rm_d     = rm_q;
        result_d = result_q;
        fflags_d = fflags_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    w_d    = {carry_in, mantissa_in};
                    e_d    = $signed({2'b00, exp_clamp});
                    stk_d  = grs_in[0];
                    sign_d = sign_in;
                    rm_d   = rm_in;
                    if (carry_in) begin
                        w_d     = {1'b0, carry_in, mantissa_in[TOP:1]};
                        stk_d   = grs_in[0] | mantissa_in[0];
                        e_d     = $signed({2'b00, exp_clamp}) + EONE;
                        state_d = S_ROUND;
                    end else if (mantissa_in == '0) begin
                        sign_d  = eff_sub_in ? (rm_in == RM_RDN) : sign_in;
                        state_d = S_ROUND;
                    end else if (mantissa_in[TOP]) begin
                        state_d = S_ROUND;
                    end else begin
                        state_d = S_NORM;
                    end
                end
            end
            S_NORM: begin
                if (w_q[TOP] || e_q == EONE) begin
                    state_d = S_ROUND;
                end else begin
                    if (w_q[TOP -: SHIFT_STEP] == '0 && e_q > ESTEP) begin
                        w_d = w_q << SHIFT_STEP;
                        e_d = e_q - ESTEP;
                    end else begin
                        w_d = w_q << 1;
                        e_d = e_q - EONE;
                    end
                    // leave as soon as the step itself reaches the target
                    if (w_d[TOP] || e_d == EONE)
                        state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                result_d = rnd_res;
                fflags_d = {2'b00, ovf, uf, nx | ovf};
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign fflags    = fflags_q;

endmodule
